// File: rtl/scan_test_controller.sv
// Scan tester: load pattern into DUT chain, pulse one capture, unload response, masked compare.
// Latency: done rises 2*CHAIN_LEN+2 cycles after the start-sampling edge; one test at a time.
// Backpressure: start is only looked at in IDLE; a start while busy is dropped, never queued.
module scan_test_controller #(
    parameter int CHAIN_LEN = 4,
    parameter int ERR_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] mask,
    input  logic                 dut_scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured,
    output logic [ERR_W-1:0]     err_count
);

    localparam int CNT_W = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_COMPARE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // sh holds the remaining stimulus bits while loading, and the response while unloading
    logic [CHAIN_LEN-1:0] sh_q, sh_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] mask_q, mask_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_in_q, scan_in_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [CHAIN_LEN-1:0] captured_q, captured_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 cmp_ok;

    assign cmp_ok = (((sh_q ^ exp_q) & mask_q) == '0);

    // Next-state and next-output logic; outputs are computed one cycle ahead so they leave flops
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        exp_d      = exp_q;
        mask_d     = mask_q;
        scan_en_d  = scan_en_q;
        scan_in_d  = scan_in_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        captured_d = captured_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // MSB goes out first; the rest waits in sh, pre-shifted
                    sh_d      = {pattern[CHAIN_LEN-2:0], 1'b0};
                    exp_d     = expected;
                    mask_d    = mask;
                    busy_d    = 1'b1;
                    scan_en_d = 1'b1;
                    scan_in_d = pattern[CHAIN_LEN-1];
                    cnt_d     = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    scan_en_d = 1'b0;
                    scan_in_d = 1'b0;
                    state_d   = S_CAPTURE;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    scan_in_d = sh_q[CHAIN_LEN-1];
                    sh_d      = {sh_q[CHAIN_LEN-2:0], 1'b0};
                end
            end
            S_CAPTURE: begin
                scan_en_d = 1'b1;
                scan_in_d = 1'b0;
                cnt_d     = '0;
                state_d   = S_UNLOAD;
            end
            S_UNLOAD: begin
                sh_d = {sh_q[CHAIN_LEN-2:0], dut_scan_out};
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    scan_en_d = 1'b0;
                    state_d   = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMPARE: begin
                captured_d = sh_q;
                pass_d     = cmp_ok;
                if (!cmp_ok && (err_q != '1)) begin
                    err_d = err_q + ERR_W'(1);
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                scan_en_d = 1'b0;
                scan_in_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any test in flight without a done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            exp_q      <= '0;
            mask_q     <= '0;
            scan_en_q  <= 1'b0;
            scan_in_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            exp_q      <= exp_d;
            mask_q     <= mask_d;
            scan_en_q  <= scan_en_d;
            scan_in_q  <= scan_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            captured_q <= captured_d;
            err_q      <= err_d;
        end
    end

    assign scan_en   = scan_en_q;
    assign scan_in   = scan_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign captured  = captured_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench: two controllers (ERR_W=8 and ERR_W=2) each driving a toy 4-bit scan chain whose
// functional capture is chain+3; a timeline model of the test sequence predicts every output.
// Directed cases pin the model with literal values, then random traffic runs against it.
module tb_scan_test_controller;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] pattern = '0, expected = '0, mask = '0;

    logic         en_a, in_a, busy_a, done_a, pass_a;
    logic [N-1:0] cap_a;
    logic [7:0]   err_a;
    logic         en_b, in_b, busy_b, done_b, pass_b;
    logic [N-1:0] cap_b;
    logic [1:0]   err_b;
    logic [N-1:0] chain_a = '0, chain_b = '0;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    scan_test_controller #(.CHAIN_LEN(N), .ERR_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .expected(expected),
        .mask(mask), .dut_scan_out(chain_a[N-1]), .scan_en(en_a), .scan_in(in_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .captured(cap_a), .err_count(err_a)
    );

    scan_test_controller #(.CHAIN_LEN(N), .ERR_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .expected(expected),
        .mask(mask), .dut_scan_out(chain_b[N-1]), .scan_en(en_b), .scan_in(in_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .captured(cap_b), .err_count(err_b)
    );

    // Toy scan-enabled datapath: shift left when scan_en, else capture chain+3
    always @(posedge clk) begin
        chain_a <= en_a ? {chain_a[N-2:0], in_a} : chain_a + 4'd3;
        chain_b <= en_b ? {chain_b[N-2:0], in_b} : chain_b + 4'd3;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a test is a timeline of 2N+2 cycles counted from the accept edge
    bit         m_active;
    int         m_off;
    logic [N-1:0] m_pat, m_exp, m_mask, m_cap;
    logic       m_pass, m_done;
    logic [7:0] m_err8;
    logic [1:0] m_err2;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_off = 0; m_pat = '0; m_exp = '0; m_mask = '0;
            m_cap = '0; m_pass = 0; m_done = 0; m_err8 = '0; m_err2 = '0;
        end else begin
            m_done = 0;
            if (m_active) begin
                if (m_off == 2*N+1) begin
                    m_cap  = m_pat + 4'd3;
                    m_pass = (((m_cap ^ m_exp) & m_mask) == 0);
                    if (!m_pass) begin
                        if (m_err8 != 8'hFF) m_err8 = m_err8 + 8'd1;
                        if (m_err2 != 2'b11) m_err2 = m_err2 + 2'd1;
                    end
                    m_done   = 1;
                    m_active = 0;
                end else begin
                    m_off++;
                end
            end else if (start) begin
                m_pat = pattern; m_exp = expected; m_mask = mask;
                m_active = 1; m_off = 0;
            end
        end
    end

    // Every-cycle comparison of both controllers against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic e_en, e_in;
            e_en = m_active && ((m_off < N) || (m_off >= N+1 && m_off <= 2*N));
            e_in = (m_active && m_off < N) ? m_pat[N-1-m_off] : 1'b0;
            chk("scan_en_a", 32'(en_a), 32'(e_en));
            chk("scan_in_a", 32'(in_a), 32'(e_in));
            chk("busy_a", 32'(busy_a), 32'(m_active));
            chk("done_a", 32'(done_a), 32'(m_done));
            chk("pass_a", 32'(pass_a), 32'(m_pass));
            chk("captured_a", 32'(cap_a), 32'(m_cap));
            chk("err_a", 32'(err_a), 32'(m_err8));
            chk("scan_en_b", 32'(en_b), 32'(e_en));
            chk("scan_in_b", 32'(in_b), 32'(e_in));
            chk("done_b", 32'(done_b), 32'(m_done));
            chk("err_b", 32'(err_b), 32'(m_err2));
        end
    end

    // Present a test and pulse start for one cycle; returns at the first negedge after accept
    task automatic pulse_start(input logic [N-1:0] p, input logic [N-1:0] e, input logic [N-1:0] m);
        @(negedge clk);
        pattern = p; expected = e; mask = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int already, output int cyc);
        cyc = already;
        while (done_a !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 40) chk("done_timeout", 32'(cyc), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, dcnt;
        int seq[5] = '{1, 2, 3, 3, 3};

        repeat (2) @(negedge clk);
        chk("rst_scan_en", 32'(en_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_captured", 32'(cap_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        rst = 1'b1;
        chk_en = 1;
        repeat (2) @(negedge clk);

        // 1: chain holds the pattern after LOAD; scan_en high 4 cycles then low 1
        pulse_start(4'b1010, 4'b1101, 4'b1111);
        for (int i = 0; i < N; i++) begin
            chk("t1_scan_en_load", 32'(en_a), 32'd1);
            @(negedge clk);
        end
        chk("t1_scan_en_capture", 32'(en_a), 32'd0);
        chk("t1_chain_loaded", 32'(chain_a), 32'hA);
        wait_done(N, lat);
        chk("t1_captured", 32'(cap_a), 32'hD);
        repeat (2) @(negedge clk);

        // 2: 0100+3 = 0111 against full mask, done 10 cycles after start
        pulse_start(4'b0100, 4'b0111, 4'b1111);
        wait_done(0, lat);
        chk("t2_latency", 32'(lat), 32'd10);
        chk("t2_captured", 32'(cap_a), 32'h7);
        chk("t2_pass", 32'(pass_a), 32'd1);
        chk("t2_err", 32'(err_a), 32'd0);
        repeat (2) @(negedge clk);

        // 3: LSB mismatch fails, then masking the LSB passes
        pulse_start(4'b0100, 4'b0110, 4'b1111);
        wait_done(0, lat);
        chk("t3_pass_fail", 32'(pass_a), 32'd0);
        chk("t3_err1", 32'(err_a), 32'd1);
        repeat (2) @(negedge clk);
        pulse_start(4'b0100, 4'b0110, 4'b1110);
        wait_done(0, lat);
        chk("t3_pass_masked", 32'(pass_a), 32'd1);
        chk("t3_err_hold", 32'(err_a), 32'd1);
        repeat (2) @(negedge clk);

        // 4: a second start during LOAD is dropped
        pulse_start(4'b0001, 4'b0100, 4'b1111);
        bcnt = 0; dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            bcnt += int'(busy_a);
            dcnt += int'(done_a);
            start = (i == 1);
            @(negedge clk);
        end
        chk("t4_busy_cycles", 32'(bcnt), 32'd10);
        chk("t4_done_count", 32'(dcnt), 32'd1);
        chk("t4_pass", 32'(pass_a), 32'd1);

        // 5: reset during UNLOAD clears everything at once and yields no done
        pulse_start(4'b0101, 4'b1000, 4'b1111);
        repeat (N+2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t5_scan_en", 32'(en_a), 32'd0);
        chk("t5_busy", 32'(busy_a), 32'd0);
        chk("t5_pass", 32'(pass_a), 32'd0);
        chk("t5_err", 32'(err_a), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dcnt += int'(done_a);
        end
        chk("t5_no_done", 32'(dcnt), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start(4'b0011, 4'b0110, 4'b1111);
        wait_done(0, lat);
        chk("t5_after_pass", 32'(pass_a), 32'd1);
        repeat (2) @(negedge clk);

        // 6: five failures saturate the 2-bit counter at 3; mask 0 still passes
        for (int t = 0; t < 5; t++) begin
            pulse_start(4'b0000, 4'b0000, 4'b1111);
            wait_done(0, lat);
            chk("t6_err_b", 32'(err_b), 32'(seq[t]));
            chk("t6_err_a", 32'(err_a), 32'(t + 1));
            @(negedge clk);
        end
        pulse_start(4'b0000, 4'b0000, 4'b0000);
        wait_done(0, lat);
        chk("t6_mask0_pass", 32'(pass_a), 32'd1);

        // Random traffic: inputs change every cycle, starts arrive at random, including while busy
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            pattern = N'($urandom);
            case ($urandom_range(0, 3))
                0: mask = '0;
                1: mask = '1;
                default: mask = N'($urandom);
            endcase
            expected = ($urandom_range(0, 1) == 1) ? pattern + 4'd3 : N'($urandom);
            start = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
